// File: rtl/mips_step_controller.sv
// Paces the single-cycle MIPS core: debounced button, single-step / divided free-run / PC breakpoint halt.
// A step decided in cycle T drives o_cpu_ce in T+1 only; the core has no backpressure path, it simply stalls while o_cpu_ce=0.
module mips_step_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 25_000_000,
  parameter int PC_W            = 32,
  parameter int CNT_W           = 16
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             i_button,
  input  logic             i_run,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_cpu_ce,
  output logic [CNT_W-1:0] o_step_cnt,
  output logic [1:0]       o_state,
  output logic             o_btn_clean
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(RUN_DIV + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  logic             btn_meta, btn_s;
  logic             run_meta, run_s;
  logic [DB_W-1:0]  db_cnt;
  logic             btn_clean, btn_clean_d;
  logic             press;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             bp_hit;
  logic             bp_skip;
  logic             cpu_ce;
  logic [CNT_W-1:0] step_cnt;
  state_t           state;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      run_meta <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      btn_meta <= i_button;
      btn_s    <= btn_meta;
      run_meta <= i_run;
      run_s    <= run_meta;
    end
  end

  // Any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
    end else begin
      btn_clean_d <= btn_clean;
      if (btn_s == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        btn_clean <= ~btn_clean;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

  assign press  = btn_clean & ~btn_clean_d;
  assign tick   = (div_cnt == DIV_LAST);
  assign bp_hit = i_bp_en && (i_pc == i_bp_addr);

  // bp_skip lets RUN leave a PC that is already parked on the breakpoint.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bp_skip  <= 1'b0;
      cpu_ce   <= 1'b0;
      step_cnt <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (cpu_ce && (step_cnt != CNT_MAX)) begin
        step_cnt <= step_cnt + CNT_ONE;
      end
      case (state)
        S_IDLE: begin
          if (press) begin
            if (run_s) begin
              state   <= S_RUN;
              div_cnt <= '0;
              bp_skip <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end
        end
        S_STEP: begin
          cpu_ce <= 1'b1;
          state  <= S_IDLE;
        end
        S_RUN: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
          if (press || !run_s) begin
            state <= S_IDLE;
          end else if (tick && bp_hit && !bp_skip) begin
            state <= S_HALT;
          end else if (tick) begin
            cpu_ce  <= 1'b1;
            bp_skip <= 1'b0;
          end
        end
        S_HALT: begin
          if (press) begin
            state <= S_STEP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_cpu_ce    = cpu_ce;
  assign o_step_cnt  = step_cnt;
  assign o_state     = state;
  assign o_btn_clean = btn_clean;

endmodule
